pe_sequencer: RTL and testbench

Initiator and reader for the background-removal processing element (pe). Latches one frame plus removal settings on a host Go request. Drives the pe through its sum phase, then computes per-channel expected colours from the returned sums. Drives the removal phase, then streams the processed pixels out one per handshake before releasing the pe with Ack.

---
 rtl/pe_pkg.sv | 51 +++++
 rtl/pe_sequencer_serializer.sv | 86 ++++++++
 rtl/pe_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_pe_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and helpers for the background-removal pe sequencer.
// The mean helper is kept here so that future multi-pe summation logic can reuse it.
package pe_pkg;

  localparam int PIXEL_W = 8;
  localparam logic [63:0] PIX_MAX = (64'd1 << PIXEL_W) - 64'd1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_SUM_START = 4'd1,
    ST_SUM_WAIT  = 4'd2,
    ST_EXP_CALC  = 4'd3,
    ST_BG_START  = 4'd4,
    ST_BG_WAIT   = 4'd5,
    ST_STREAM    = 4'd6,
    ST_ACK       = 4'd7,
    ST_ERR       = 4'd8
  } pe_state_e;

  typedef struct packed {
    logic [PIXEL_W-1:0] threshold;
    logic [PIXEL_W-1:0] bg_r;
    logic [PIXEL_W-1:0] bg_g;
    logic [PIXEL_W-1:0] bg_b;
  } pe_settings_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  // Truncating mean of a power-of-two pixel count, saturated to one channel.
  function automatic logic [PIXEL_W-1:0] sat_mean(input logic [63:0] sum, input int shift);
    logic [63:0] mean;
    mean = sum >> shift;
    if (mean > PIX_MAX) begin
      return {PIXEL_W{1'b1}};
    end else begin
      return mean[PIXEL_W-1:0];
    end
  endfunction

endpackage

// File: rtl/pe_sequencer_serializer.sv
// Capture buffer and valid/ready pixel streamer for the pe sequencer.
// Holds the processed frame and presents one pixel per accepted handshake.
module pe_pixel_serializer
  import pe_pkg::*;
#(
  parameter int NUM_PIXELS = 4,
  localparam int FRAME_W = PIXEL_W * NUM_PIXELS,
  localparam int IDX_W = clog2(NUM_PIXELS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [FRAME_W-1:0] pix_r,
  input  logic [FRAME_W-1:0] pix_g,
  input  logic [FRAME_W-1:0] pix_b,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [PIXEL_W-1:0] out_r,
  output logic [PIXEL_W-1:0] out_g,
  output logic [PIXEL_W-1:0] out_b,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last,
  output logic               complete
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);

  logic [FRAME_W-1:0] buf_r_q, buf_r_d, buf_g_q, buf_g_d, buf_b_q, buf_b_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               at_last_s;

  assign at_last_s = (idx_q == LAST_IDX);
  assign complete  = valid_q & out_ready & at_last_s;

  // Load, advance or hold the buffer and pixel index.
  always_comb begin
    buf_r_d = buf_r_q;
    buf_g_d = buf_g_q;
    buf_b_d = buf_b_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (load) begin
      buf_r_d = pix_r;
      buf_g_d = pix_g;
      buf_b_d = pix_b;
      idx_d   = {IDX_W{1'b0}};
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      if (at_last_s) begin
        idx_d   = {IDX_W{1'b0}};
        valid_d = 1'b0;
      end else begin
        idx_d   = idx_q + IDX_W'(1);
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Stream state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_r_q <= {FRAME_W{1'b0}};
      buf_g_q <= {FRAME_W{1'b0}};
      buf_b_q <= {FRAME_W{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      buf_r_q <= buf_r_d;
      buf_g_q <= buf_g_d;
      buf_b_q <= buf_b_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  // Pixel buses read zero whenever nothing is being offered.
  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_last  = valid_q & at_last_s;
  assign out_r     = valid_q ? buf_r_q[int'(idx_q)*PIXEL_W +: PIXEL_W] : {PIXEL_W{1'b0}};
  assign out_g     = valid_q ? buf_g_q[int'(idx_q)*PIXEL_W +: PIXEL_W] : {PIXEL_W{1'b0}};
  assign out_b     = valid_q ? buf_b_q[int'(idx_q)*PIXEL_W +: PIXEL_W] : {PIXEL_W{1'b0}};

endmodule

// File: rtl/pe_sequencer.sv
// Host-facing sequencer for the background-removal pe: sum phase, expected-colour
// calculation, removal phase, then a pixel stream before releasing the pe.
module pe_sequencer
  import pe_pkg::*;
#(
  parameter int NUM_PIXELS = 4,
  parameter int SUM_W = 32,
  parameter int TIMEOUT = 1024,
  localparam int FRAME_W = PIXEL_W * NUM_PIXELS,
  localparam int IDX_W = clog2(NUM_PIXELS)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Go,
  input  logic [FRAME_W-1:0] frame_r,
  input  logic [FRAME_W-1:0] frame_g,
  input  logic [FRAME_W-1:0] frame_b,
  input  logic [PIXEL_W-1:0] threshold_in,
  input  logic [PIXEL_W-1:0] bg_r_in,
  input  logic [PIXEL_W-1:0] bg_g_in,
  input  logic [PIXEL_W-1:0] bg_b_in,
  output logic [FRAME_W-1:0] pe_red_in,
  output logic [FRAME_W-1:0] pe_green_in,
  output logic [FRAME_W-1:0] pe_blue_in,
  output logic [PIXEL_W-1:0] pe_threshold,
  output logic [PIXEL_W-1:0] pe_desired_bg_r,
  output logic [PIXEL_W-1:0] pe_desired_bg_g,
  output logic [PIXEL_W-1:0] pe_desired_bg_b,
  output logic [PIXEL_W-1:0] pe_red_exp,
  output logic [PIXEL_W-1:0] pe_green_exp,
  output logic [PIXEL_W-1:0] pe_blue_exp,
  output logic               pe_start_sum,
  output logic               pe_start_bg,
  output logic               pe_ack,
  input  logic               pe_qsd,
  input  logic               pe_qbgd,
  input  logic [SUM_W-1:0]   pe_red_sum,
  input  logic [SUM_W-1:0]   pe_green_sum,
  input  logic [SUM_W-1:0]   pe_blue_sum,
  input  logic [FRAME_W-1:0] pe_red_out,
  input  logic [FRAME_W-1:0] pe_green_out,
  input  logic [FRAME_W-1:0] pe_blue_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIXEL_W-1:0] out_r,
  output logic [PIXEL_W-1:0] out_g,
  output logic [PIXEL_W-1:0] out_b,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int WD_W = clog2(TIMEOUT + 1);
  localparam int SHIFT = clog2(NUM_PIXELS);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  pe_state_e          state_q, state_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [FRAME_W-1:0] fr_q, fr_d, fg_q, fg_d, fb_q, fb_d;
  pe_settings_t       set_q, set_d;
  logic [PIXEL_W-1:0] exp_r_q, exp_r_d, exp_g_q, exp_g_d, exp_b_q, exp_b_d;
  logic               start_sum_q, start_sum_d, start_bg_q, start_bg_d;
  logic               ack_q, ack_d, done_q, done_d, error_q, error_d;
  logic               load_s, complete_s;

  // Next-state and registered-output decode; strobes are set on entry to their state.
  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    fr_d        = fr_q;
    fg_d        = fg_q;
    fb_d        = fb_q;
    set_d       = set_q;
    exp_r_d     = exp_r_q;
    exp_g_d     = exp_g_q;
    exp_b_d     = exp_b_q;
    start_sum_d = 1'b0;
    start_bg_d  = 1'b0;
    ack_d       = 1'b0;
    done_d      = 1'b0;
    error_d     = error_q;
    load_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Go) begin
          fr_d        = frame_r;
          fg_d        = frame_g;
          fb_d        = frame_b;
          set_d       = '{threshold: threshold_in, bg_r: bg_r_in, bg_g: bg_g_in, bg_b: bg_b_in};
          error_d     = 1'b0;
          start_sum_d = 1'b1;
          state_d     = ST_SUM_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SUM_START: begin
        wd_d    = {WD_W{1'b0}};
        state_d = ST_SUM_WAIT;
      end
      ST_SUM_WAIT: begin
        if (pe_qsd) begin
          ack_d   = 1'b1;
          state_d = ST_EXP_CALC;
        end else if (wd_q == WD_LAST) begin
          ack_d   = 1'b1;
          error_d = 1'b1;
          state_d = ST_ERR;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ST_EXP_CALC: begin
        exp_r_d    = sat_mean(64'(pe_red_sum), SHIFT);
        exp_g_d    = sat_mean(64'(pe_green_sum), SHIFT);
        exp_b_d    = sat_mean(64'(pe_blue_sum), SHIFT);
        start_bg_d = 1'b1;
        state_d    = ST_BG_START;
      end
      ST_BG_START: begin
        wd_d    = {WD_W{1'b0}};
        state_d = ST_BG_WAIT;
      end
      ST_BG_WAIT: begin
        if (pe_qbgd) begin
          load_s  = 1'b1;
          state_d = ST_STREAM;
        end else if (wd_q == WD_LAST) begin
          ack_d   = 1'b1;
          error_d = 1'b1;
          state_d = ST_ERR;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ST_STREAM: begin
        if (complete_s) begin
          ack_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_ACK;
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      wd_q        <= {WD_W{1'b0}};
      fr_q        <= {FRAME_W{1'b0}};
      fg_q        <= {FRAME_W{1'b0}};
      fb_q        <= {FRAME_W{1'b0}};
      set_q       <= '0;
      exp_r_q     <= {PIXEL_W{1'b0}};
      exp_g_q     <= {PIXEL_W{1'b0}};
      exp_b_q     <= {PIXEL_W{1'b0}};
      start_sum_q <= 1'b0;
      start_bg_q  <= 1'b0;
      ack_q       <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      fr_q        <= fr_d;
      fg_q        <= fg_d;
      fb_q        <= fb_d;
      set_q       <= set_d;
      exp_r_q     <= exp_r_d;
      exp_g_q     <= exp_g_d;
      exp_b_q     <= exp_b_d;
      start_sum_q <= start_sum_d;
      start_bg_q  <= start_bg_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  pe_pixel_serializer #(.NUM_PIXELS(NUM_PIXELS)) u_serializer (
    .clk       (Clk),
    .rst       (Reset),
    .load      (load_s),
    .pix_r     (pe_red_out),
    .pix_g     (pe_green_out),
    .pix_b     (pe_blue_out),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_r     (out_r),
    .out_g     (out_g),
    .out_b     (out_b),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .complete  (complete_s)
  );

  assign pe_red_in       = fr_q;
  assign pe_green_in     = fg_q;
  assign pe_blue_in      = fb_q;
  assign pe_threshold    = set_q.threshold;
  assign pe_desired_bg_r = set_q.bg_r;
  assign pe_desired_bg_g = set_q.bg_g;
  assign pe_desired_bg_b = set_q.bg_b;
  assign pe_red_exp      = exp_r_q;
  assign pe_green_exp    = exp_g_q;
  assign pe_blue_exp     = exp_b_q;
  assign pe_start_sum    = start_sum_q;
  assign pe_start_bg     = start_bg_q;
  assign pe_ack          = ack_q;
  assign busy            = (state_q != ST_IDLE);
  assign done            = done_q;
  assign error           = error_q;

endmodule

// File: tb/tb_pe_sequencer.sv
// Self-checking bench for pe_sequencer with a behavioural pe stub and stream sink.
module tb_pe_sequencer;

  localparam int NP = 4;
  localparam int PW = 8;
  localparam int SW = 32;
  localparam int TO = 32;
  localparam int FW = NP * PW;

  logic          Clk = 1'b0;
  logic          Reset, Go, pe_qsd, pe_qbgd, out_ready;
  logic [FW-1:0] frame_r, frame_g, frame_b, pe_red_out, pe_green_out, pe_blue_out;
  logic [PW-1:0] threshold_in, bg_r_in, bg_g_in, bg_b_in;
  logic [SW-1:0] pe_red_sum, pe_green_sum, pe_blue_sum;
  logic [FW-1:0] pe_red_in, pe_green_in, pe_blue_in;
  logic [PW-1:0] pe_threshold, pe_desired_bg_r, pe_desired_bg_g, pe_desired_bg_b;
  logic [PW-1:0] pe_red_exp, pe_green_exp, pe_blue_exp, out_r, out_g, out_b;
  logic          pe_start_sum, pe_start_bg, pe_ack, out_valid, out_last, busy, done, error;
  logic [1:0]    out_idx;

  int checks = 0;
  int errors = 0;
  int pcyc = 0;
  int done_cnt = 0;
  int ack_cnt = 0;

  pe_sequencer #(.NUM_PIXELS(NP), .SUM_W(SW), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset), .Go(Go),
    .frame_r(frame_r), .frame_g(frame_g), .frame_b(frame_b),
    .threshold_in(threshold_in), .bg_r_in(bg_r_in), .bg_g_in(bg_g_in), .bg_b_in(bg_b_in),
    .pe_red_in(pe_red_in), .pe_green_in(pe_green_in), .pe_blue_in(pe_blue_in),
    .pe_threshold(pe_threshold), .pe_desired_bg_r(pe_desired_bg_r),
    .pe_desired_bg_g(pe_desired_bg_g), .pe_desired_bg_b(pe_desired_bg_b),
    .pe_red_exp(pe_red_exp), .pe_green_exp(pe_green_exp), .pe_blue_exp(pe_blue_exp),
    .pe_start_sum(pe_start_sum), .pe_start_bg(pe_start_bg), .pe_ack(pe_ack),
    .pe_qsd(pe_qsd), .pe_qbgd(pe_qbgd),
    .pe_red_sum(pe_red_sum), .pe_green_sum(pe_green_sum), .pe_blue_sum(pe_blue_sum),
    .pe_red_out(pe_red_out), .pe_green_out(pe_green_out), .pe_blue_out(pe_blue_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_idx(out_idx), .out_last(out_last),
    .busy(busy), .done(done), .error(error)
  );

  always #5 Clk = ~Clk;

  // Cycle counter and pulse counters, sampled at the edge that ends each cycle.
  always @(posedge Clk) begin
    pcyc++;
    if (done === 1'b1) done_cnt++;
    if (pe_ack === 1'b1) ack_cnt++;
  end

  function automatic logic [PW-1:0] mean_model(input logic [SW-1:0] s);
    int unsigned m;
    m = s / NP;
    if (m > 255) return 8'd255;
    return m[PW-1:0];
  endfunction

  function automatic bit all_zero();
    return (pe_red_in == 0) && (pe_green_in == 0) && (pe_blue_in == 0) && (pe_threshold == 0) &&
           (pe_desired_bg_r == 0) && (pe_desired_bg_g == 0) && (pe_desired_bg_b == 0) &&
           (pe_red_exp == 0) && (pe_green_exp == 0) && (pe_blue_exp == 0) &&
           (pe_start_sum == 0) && (pe_start_bg == 0) && (pe_ack == 0) && (out_valid == 0) &&
           (out_r == 0) && (out_g == 0) && (out_b == 0) && (out_idx == 0) && (out_last == 0) &&
           (busy == 0) && (done == 0) && (error == 0);
  endfunction

  // One full pe transaction; d/e delay the done flags, abort_idx >= 0 resets mid-stream.
  task automatic run_frame(input int d, input int e, input int stall_idx, input int stall_len,
                           input bit go_glitch, input int abort_idx);
    logic [FW-1:0] fr, fg, fb;
    logic [PW-1:0] thr, er, eg, eb;
    logic [PW-1:0] mr[NP], mg[NP], mb[NP];
    int p0, rcv, guard, stall, d0, a0;
    fr = frame_r; fg = frame_g; fb = frame_b; thr = threshold_in;
    er = mean_model(pe_red_sum); eg = mean_model(pe_green_sum); eb = mean_model(pe_blue_sum);
    for (int i = 0; i < NP; i++) begin
      mr[i] = pe_red_out[i*PW +: PW]; mg[i] = pe_green_out[i*PW +: PW]; mb[i] = pe_blue_out[i*PW +: PW];
    end
    d0 = done_cnt; a0 = ack_cnt;
    Go = 1'b1; p0 = pcyc;
    @(negedge Clk); Go = 1'b0;
    checks++;
    if (pe_start_sum !== 1'b1 || busy !== 1'b1 || error !== 1'b0) begin
      errors++; $display("FAIL go_accept: start_sum=%b busy=%b error=%b, required 1 1 0", pe_start_sum, busy, error);
    end
    checks++;
    if (pe_red_in !== fr || pe_green_in !== fg || pe_blue_in !== fb || pe_threshold !== thr ||
        pe_desired_bg_r !== bg_r_in || pe_desired_bg_g !== bg_g_in || pe_desired_bg_b !== bg_b_in) begin
      errors++; $display("FAIL latch: red_in=%h thr=%0d, required %h %0d", pe_red_in, pe_threshold, fr, thr);
    end
    frame_r = $urandom; threshold_in = PW'($urandom);
    @(negedge Clk);
    checks++;
    if (pe_start_sum !== 1'b0) begin
      errors++; $display("FAIL start_sum_width: start_sum=%b, required 0", pe_start_sum);
    end
    repeat (d) @(negedge Clk);
    pe_qsd = 1'b1;
    guard = 0;
    while (pe_ack !== 1'b1 && guard < TO + 8) begin @(negedge Clk); guard++; end
    checks++;
    if (pe_ack !== 1'b1 || error !== 1'b0 || guard != 1) begin
      errors++; $display("FAIL sum_ack: ack=%b error=%b wait=%0d, required 1 0 1", pe_ack, error, guard);
    end
    pe_qsd = 1'b0;
    @(negedge Clk);
    checks++;
    if (pe_start_bg !== 1'b1 || pe_ack !== 1'b0) begin
      errors++; $display("FAIL start_bg: start_bg=%b ack=%b, required 1 0", pe_start_bg, pe_ack);
    end
    checks++;
    if (pe_red_exp !== er || pe_green_exp !== eg || pe_blue_exp !== eb) begin
      errors++; $display("FAIL exp: got %0d/%0d/%0d, required %0d/%0d/%0d",
                         pe_red_exp, pe_green_exp, pe_blue_exp, er, eg, eb);
    end
    @(negedge Clk);
    if (go_glitch) begin
      Go = 1'b1; frame_r = ~fr;
      @(negedge Clk); Go = 1'b0;
    end
    repeat (e) @(negedge Clk);
    pe_qbgd = 1'b1;
    guard = 0;
    while (out_valid !== 1'b1 && guard < TO + 8) begin @(negedge Clk); guard++; end
    checks++;
    if (out_valid !== 1'b1 || pcyc - p0 != 6 + d + e + int'(go_glitch)) begin
      errors++; $display("FAIL latency: valid=%b cycles=%0d, required 1 %0d",
                         out_valid, pcyc - p0, 6 + d + e + int'(go_glitch));
    end
    pe_red_out = $urandom; pe_green_out = $urandom; pe_blue_out = $urandom;
    rcv = 0; guard = 0; stall = 0;
    while (rcv < NP && guard < 200) begin
      if (rcv == abort_idx) begin
        Reset = 1'b1; #1;
        checks++;
        if (!all_zero()) begin
          errors++; $display("FAIL reset_abort: busy=%b valid=%b idx=%0d ack=%b red_in=%h, required all 0",
                             busy, out_valid, out_idx, pe_ack, pe_red_in);
        end
        out_ready = 1'b0; pe_qbgd = 1'b0;
        return;
      end
      checks++;
      if (out_valid !== 1'b1 || out_idx !== rcv[1:0] || out_last !== (rcv == NP - 1)) begin
        errors++; $display("FAIL stream_ctrl: valid=%b idx=%0d last=%b, required 1 %0d %b",
                           out_valid, out_idx, out_last, rcv, rcv == NP - 1);
      end
      checks++;
      if (out_r !== mr[rcv] || out_g !== mg[rcv] || out_b !== mb[rcv]) begin
        errors++; $display("FAIL stream_data: px%0d got %0d/%0d/%0d, required %0d/%0d/%0d",
                           rcv, out_r, out_g, out_b, mr[rcv], mg[rcv], mb[rcv]);
      end
      if (rcv == stall_idx && stall < stall_len) begin
        out_ready = 1'b0; stall++;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
      if (out_ready) rcv++;
      @(negedge Clk); guard++;
    end
    out_ready = 1'b0;
    checks++;
    if (rcv != NP || pe_ack !== 1'b1 || done !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL ack_done: pixels=%0d ack=%b done=%b valid=%b, required %0d 1 1 0",
                         rcv, pe_ack, done, out_valid, NP);
    end
    checks++;
    if (pe_red_in !== fr || pe_threshold !== thr) begin
      errors++; $display("FAIL latch_hold: red_in=%h thr=%0d, required %h %0d", pe_red_in, pe_threshold, fr, thr);
    end
    @(negedge Clk); pe_qbgd = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pe_ack !== 1'b0) begin
      errors++; $display("FAIL back_idle: busy=%b done=%b ack=%b, required 0 0 0", busy, done, pe_ack);
    end
    checks++;
    if (done_cnt - d0 != 1 || ack_cnt - a0 != 2) begin
      errors++; $display("FAIL pulse_count: done=%0d ack=%0d, required 1 2", done_cnt - d0, ack_cnt - a0);
    end
  endtask

  task automatic randomize_job(input int max_sum);
    frame_r = $urandom; frame_g = $urandom; frame_b = $urandom;
    threshold_in = PW'($urandom); bg_r_in = PW'($urandom); bg_g_in = PW'($urandom); bg_b_in = PW'($urandom);
    pe_red_sum = $urandom_range(0, max_sum); pe_green_sum = $urandom_range(0, max_sum);
    pe_blue_sum = $urandom_range(0, max_sum);
    pe_red_out = $urandom; pe_green_out = $urandom; pe_blue_out = $urandom;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Go = 1'b0; pe_qsd = 1'b0; pe_qbgd = 1'b0; out_ready = 1'b0;
    randomize_job(1000);
    repeat (2) @(negedge Clk);
    checks++;
    if (!all_zero()) begin
      errors++; $display("FAIL reset_state: busy=%b valid=%b error=%b red_in=%h, required all 0",
                         busy, out_valid, error, pe_red_in);
    end
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_nominal();
    frame_r = {8'd61, 8'd61, 8'd61, 8'd204};
    frame_g = {8'd133, 8'd133, 8'd133, 8'd0};
    frame_b = {8'd198, 8'd198, 8'd198, 8'd0};
    threshold_in = 8'd60; bg_r_in = 8'd106; bg_g_in = 8'd168; bg_b_in = 8'd79;
    pe_red_sum = 32'd387; pe_green_sum = 32'd399; pe_blue_sum = 32'd594;
    pe_red_out = $urandom; pe_green_out = $urandom; pe_blue_out = $urandom;
    run_frame(0, 0, -1, 0, 1'b0, -1);
    checks++;
    if (pe_red_exp !== 8'd96 || pe_green_exp !== 8'd99 || pe_blue_exp !== 8'd148) begin
      errors++; $display("FAIL nominal_exp: %0d/%0d/%0d, required 96/99/148", pe_red_exp, pe_green_exp, pe_blue_exp);
    end
    checks++;
    if (pe_threshold !== 8'd60 || pe_desired_bg_r !== 8'd106 || pe_desired_bg_g !== 8'd168 ||
        pe_desired_bg_b !== 8'd79) begin
      errors++; $display("FAIL nominal_settings: %0d/%0d/%0d/%0d, required 60/106/168/79",
                         pe_threshold, pe_desired_bg_r, pe_desired_bg_g, pe_desired_bg_b);
    end
  endtask

  task automatic test_backpressure();
    randomize_job(1020);
    run_frame(1, 2, 1, 5, 1'b0, -1);
  endtask

  task automatic test_saturation();
    randomize_job(1200);
    pe_red_sum = 32'd2000;
    run_frame(0, 1, -1, 0, 1'b0, -1);
    checks++;
    if (pe_red_exp !== 8'd255) begin
      errors++; $display("FAIL saturation: red_exp=%0d, required 255", pe_red_exp);
    end
  endtask

  task automatic test_timeout();
    int n, d0, a0;
    randomize_job(1000);
    pe_qsd = 1'b0; d0 = done_cnt; a0 = ack_cnt;
    Go = 1'b1;
    @(negedge Clk); Go = 1'b0;
    n = 0;
    while (pe_ack !== 1'b1 && n < TO + 10) begin @(negedge Clk); n++; end
    checks++;
    if (n != TO + 1 || error !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL timeout: cycles=%0d error=%b done=%b, required %0d 1 0", n, error, done, TO + 1);
    end
    @(negedge Clk);
    checks++;
    if (busy !== 1'b0 || error !== 1'b1 || pe_ack !== 1'b0 || done_cnt != d0 || ack_cnt - a0 != 1) begin
      errors++; $display("FAIL timeout_idle: busy=%b error=%b acks=%0d dones=%0d, required 0 1 1 0",
                         busy, error, ack_cnt - a0, done_cnt - d0);
    end
    repeat (3) @(negedge Clk);
    checks++;
    if (error !== 1'b1) begin
      errors++; $display("FAIL error_sticky: error=%b, required 1", error);
    end
    randomize_job(1000);
    run_frame(0, 0, -1, 0, 1'b0, -1);
  endtask

  task automatic test_go_while_busy();
    randomize_job(1020);
    run_frame(0, 2, -1, 0, 1'b1, -1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      randomize_job(1400);
      run_frame($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 4), 1'($urandom_range(0, 1)), -1);
    end
  endtask

  task automatic test_reset_mid_stream();
    int d0, a0;
    randomize_job(1000);
    d0 = done_cnt; a0 = ack_cnt;
    run_frame(0, 0, -1, 0, 1'b0, 2);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    checks++;
    if (busy !== 1'b0 || done_cnt != d0 || ack_cnt - a0 != 1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_no_ack: busy=%b dones=%0d acks=%0d, required 0 0 1",
                         busy, done_cnt - d0, ack_cnt - a0);
    end
    randomize_job(1000);
    run_frame(0, 0, -1, 0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_saturation();
    test_timeout();
    test_go_while_busy();
    test_random();
    test_reset_mid_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
